// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin two-port arbiter in front of a shared combinational ALU
//
// Purpose: shares one combinational ALU between port 0 (execute stage) and port 1
// (auxiliary unit). Requests are accepted in IDLE, operands are registered onto the
// ALU inputs, the ALU result is captured one cycle later, and the response is held
// for the owning port until it accepts it.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid[1:0]/req_ready[1:0] per-port request handshake
//   req_ctrl0/req_op1_0/req_op2_0 port 0 request fields
//   req_ctrl1/req_op1_1/req_op2_1 port 1 request fields
//   rsp_valid[1:0]/rsp_ready[1:0] per-port response handshake (rsp_valid one-hot)
//   rsp_result/rsp_eq/rsp_err     captured response
//   alu_op1/alu_op2/alu_ctrl      registered drive into the ALU
//   alu_out/alu_eq                ALU outputs
module alu_arbiter #(
    parameter int Data_Width = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [3:0]            req_ctrl0,
    input  logic [Data_Width-1:0] req_op1_0,
    input  logic [Data_Width-1:0] req_op2_0,
    input  logic [3:0]            req_ctrl1,
    input  logic [Data_Width-1:0] req_op1_1,
    input  logic [Data_Width-1:0] req_op2_1,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [Data_Width-1:0] rsp_result,
    output logic                  rsp_eq,
    output logic                  rsp_err,
    output logic [Data_Width-1:0] alu_op1,
    output logic [Data_Width-1:0] alu_op2,
    output logic [3:0]            alu_ctrl,
    input  logic [Data_Width-1:0] alu_out,
    input  logic                  alu_eq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  last_grant;
    logic                  owner;
    logic                  err_q;

    logic                  grant_port;
    logic                  accept;
    logic [3:0]            sel_ctrl;
    logic [Data_Width-1:0] sel_op1;
    logic [Data_Width-1:0] sel_op2;
    logic                  sel_illegal;

    // Round-robin: on contention the port that did not win last time is chosen.
    // last_grant resets to 1 so port 0 wins the first contended request.
    always_comb begin
        grant_port = 1'b0;
        if (req_valid == 2'b11) begin
            grant_port = ~last_grant;
        end else if (req_valid[1]) begin
            grant_port = 1'b1;
        end
    end

    assign accept = (state == IDLE) && (|req_valid);

    // rst_n gating keeps req_ready low while reset is held, even with requests pending.
    always_comb begin
        req_ready = 2'b00;
        if (accept && rst_n) begin
            req_ready[grant_port] = 1'b1;
        end
    end

    assign sel_ctrl    = grant_port ? req_ctrl1 : req_ctrl0;
    assign sel_op1     = grant_port ? req_op1_1 : req_op1_0;
    assign sel_op2     = grant_port ? req_op2_1 : req_op2_0;
    assign sel_illegal = (sel_ctrl >= 4'hA) && (sel_ctrl <= 4'hE);

    always_comb begin
        rsp_valid = 2'b00;
        if (state == RESP) begin
            rsp_valid[owner] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = EXEC;
            EXEC: state_nxt = RESP;
            RESP: if (rsp_ready[owner]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            err_q      <= 1'b0;
            rsp_result <= '0;
            rsp_eq     <= 1'b0;
            rsp_err    <= 1'b0;
            alu_op1    <= '0;
            alu_op2    <= '0;
            alu_ctrl   <= 4'b0000;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner      <= grant_port;
                        last_grant <= grant_port;
                        err_q      <= sel_illegal;
                        // Illegal codes park the ALU on a harmless all-zero operation.
                        alu_ctrl   <= sel_illegal ? 4'b0000 : sel_ctrl;
                        alu_op1    <= sel_illegal ? '0 : sel_op1;
                        alu_op2    <= sel_illegal ? '0 : sel_op2;
                    end
                end
                EXEC: begin
                    rsp_result <= err_q ? '0 : alu_out;
                    rsp_eq     <= alu_eq & ~err_q;
                    rsp_err    <= err_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a stub ALU and transaction model
module tb_alu_arbiter;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [3:0]    req_ctrl0, req_ctrl1;
    logic [DW-1:0] req_op1_0, req_op2_0, req_op1_1, req_op2_1;
    logic [1:0]    rsp_valid;
    logic [1:0]    rsp_ready;
    logic [DW-1:0] rsp_result;
    logic          rsp_eq, rsp_err;
    logic [DW-1:0] alu_op1, alu_op2;
    logic [3:0]    alu_ctrl;
    logic [DW-1:0] alu_out;
    logic          alu_eq;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_arbiter #(.Data_Width(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_ctrl0(req_ctrl0), .req_op1_0(req_op1_0), .req_op2_0(req_op2_0),
        .req_ctrl1(req_ctrl1), .req_op1_1(req_op1_1), .req_op2_1(req_op2_1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_eq(rsp_eq), .rsp_err(rsp_err),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out), .alu_eq(alu_eq)
    );

    function automatic logic [DW-1:0] ref_alu(input logic [3:0] c, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        case (c)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return a << b[4:0];
            4'h6: return a >> b[4:0];
            4'h7: return DW'($signed(a) >>> b[4:0]);
            4'h8: return ($signed(a) < $signed(b)) ? DW'(1) : DW'(0);
            4'h9: return (a < b) ? DW'(1) : DW'(0);
            4'hF: return b;
            default: return '0;
        endcase
    endfunction

    function automatic logic legal(input logic [3:0] c);
        return !((c >= 4'hA) && (c <= 4'hE));
    endfunction

    function automatic logic pick(input logic [1:0] v, input logic last);
        return (v == 2'b11) ? ~last : v[1];
    endfunction

    // Stub ALU standing in for the shared instance.
    assign alu_out = ref_alu(alu_ctrl, alu_op1, alu_op2);
    assign alu_eq  = (alu_op1 == alu_op2);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction model: phase counts where the accepted op is (0 none, 1 evaluating, 2 responding).
    int            m_phase;
    logic          m_last, m_owner, m_eq, m_err, m_peq, m_perr;
    logic [DW-1:0] m_res, m_pend, m_op1, m_op2;
    logic [3:0]    m_ctrl;
    logic          mg;
    logic [3:0]    m_sc;
    logic [DW-1:0] m_sa, m_sb;

    assign mg   = pick(req_valid, m_last);
    assign m_sc = mg ? req_ctrl1 : req_ctrl0;
    assign m_sa = mg ? req_op1_1 : req_op1_0;
    assign m_sb = mg ? req_op2_1 : req_op2_0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_last <= 1'b1; m_owner <= 1'b0;
            m_res <= '0; m_eq <= 1'b0; m_err <= 1'b0;
            m_op1 <= '0; m_op2 <= '0; m_ctrl <= 4'h0;
            m_pend <= '0; m_peq <= 1'b0; m_perr <= 1'b0;
        end else if (m_phase == 0) begin
            if (|req_valid) begin
                m_phase <= 1;
                m_owner <= mg;
                m_last  <= mg;
                m_ctrl  <= legal(m_sc) ? m_sc : 4'h0;
                m_op1   <= legal(m_sc) ? m_sa : '0;
                m_op2   <= legal(m_sc) ? m_sb : '0;
                m_pend  <= legal(m_sc) ? ref_alu(m_sc, m_sa, m_sb) : '0;
                m_peq   <= legal(m_sc) ? (m_sa == m_sb) : 1'b0;
                m_perr  <= !legal(m_sc);
            end
        end else if (m_phase == 1) begin
            m_phase <= 2;
            m_res   <= m_pend;
            m_eq    <= m_peq;
            m_err   <= m_perr;
        end else if (rsp_ready[m_owner]) begin
            m_phase <= 0;
        end
    end

    always @(negedge clk) begin
        chk("req_ready", 64'(req_ready),
            64'((m_phase == 0 && rst_n && (|req_valid)) ? (2'b01 << mg) : 2'b00));
        chk("rsp_valid", 64'(rsp_valid), 64'((m_phase == 2) ? (2'b01 << m_owner) : 2'b00));
        chk("rsp_result", 64'(rsp_result), 64'(m_res));
        chk("rsp_eq", 64'(rsp_eq), 64'(m_eq));
        chk("rsp_err", 64'(rsp_err), 64'(m_err));
        chk("alu_op1", 64'(alu_op1), 64'(m_op1));
        chk("alu_op2", 64'(alu_op2), 64'(m_op2));
        chk("alu_ctrl", 64'(alu_ctrl), 64'(m_ctrl));
    end

    // Presents one request on a port and waits (bounded) for its handshake.
    // Returns just after the accepting edge, i.e. in the evaluate cycle.
    task automatic issue(input int p, input logic [3:0] c, input logic [DW-1:0] a,
                         input logic [DW-1:0] b);
        bit done = 0;
        if (p == 0) begin req_ctrl0 = c; req_op1_0 = a; req_op2_0 = b; end
        else        begin req_ctrl1 = c; req_op1_1 = a; req_op2_1 = b; end
        req_valid[p] = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (req_ready[p]) done = 1;
        end
        if (!done) chk("issue_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        req_valid[p] = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    int      order[$];
    int      times[$];
    int      cnt0, cnt1;
    logic [1:0] hs;
    logic [3:0] p1_ctrl [4];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        p1_ctrl[0] = 4'h2; p1_ctrl[1] = 4'h5; p1_ctrl[2] = 4'h7; p1_ctrl[3] = 4'h8;
        rst_n = 1'b0;
        req_valid = 2'b00; rsp_ready = 2'b11;
        req_ctrl0 = 4'h0; req_op1_0 = '0; req_op2_0 = '0;
        req_ctrl1 = 4'h0; req_op1_1 = '0; req_op2_1 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
        chk("rst_rsp_result", 64'(rsp_result), 64'd0);
        rst_n = 1'b1;

        // 1: port 0 add
        issue(0, 4'h0, 32'd5, 32'd7);
        @(negedge clk);
        chk("t1_alu_ctrl", 64'(alu_ctrl), 64'd0);
        chk("t1_alu_op1", 64'(alu_op1), 64'd5);
        @(negedge clk);
        chk("t1_rsp_valid", 64'(rsp_valid), 64'b01);
        chk("t1_result", 64'(rsp_result), 64'd12);
        chk("t1_eq", 64'(rsp_eq), 64'd0);
        @(posedge clk); #1;

        // 3: port 1 subtract equal operands
        issue(1, 4'h1, 32'h1234, 32'h1234);
        @(negedge clk);
        @(negedge clk);
        chk("t3_rsp_valid", 64'(rsp_valid), 64'b10);
        chk("t3_result", 64'(rsp_result), 64'd0);
        chk("t3_eq", 64'(rsp_eq), 64'd1);
        @(posedge clk); #1;

        // 4: illegal code, then a legal op
        issue(0, 4'hC, 32'd9, 32'd9);
        @(negedge clk);
        chk("t4_alu_ctrl", 64'(alu_ctrl), 64'd0);
        chk("t4_alu_op1", 64'(alu_op1), 64'd0);
        @(negedge clk);
        chk("t4_err", 64'(rsp_err), 64'd1);
        chk("t4_result", 64'(rsp_result), 64'd0);
        chk("t4_eq", 64'(rsp_eq), 64'd0);
        @(posedge clk); #1;
        issue(0, 4'h3, 32'd6, 32'd3);
        @(negedge clk);
        @(negedge clk);
        chk("t4b_err", 64'(rsp_err), 64'd0);
        chk("t4b_result", 64'(rsp_result), 64'd7);
        @(posedge clk); #1;

        // 5: response backpressure with port 1 waiting
        rsp_ready = 2'b00;
        issue(0, 4'h2, 32'hFF, 32'h0F);
        req_ctrl1 = 4'h0; req_op1_1 = 32'd1; req_op2_1 = 32'd1;
        req_valid[1] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("t5_req_ready_hold", 64'(req_ready), 64'd0);
            if (i >= 1) begin
                chk("t5_result_hold", 64'(rsp_result), 64'h0F);
                chk("t5_valid_hold", 64'(rsp_valid), 64'b01);
            end
        end
        @(posedge clk); #1;
        rsp_ready = 2'b11;
        @(posedge clk);
        @(negedge clk);
        chk("t5_grant_after_release", 64'(req_ready), 64'b10);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t5_p1_valid", 64'(rsp_valid), 64'b10);
        chk("t5_p1_result", 64'(rsp_result), 64'd2);
        @(posedge clk); #1;

        // 2: both ports valid continuously from reset
        req_valid = 2'b11;
        req_ctrl0 = 4'h0; req_op1_0 = 32'd1; req_op2_0 = 32'd100;
        req_ctrl1 = p1_ctrl[0]; req_op1_1 = 32'hF0F0_0000; req_op2_1 = 32'd1;
        do_reset();
        cnt0 = 0; cnt1 = 0;
        for (int c = 0; c < 80 && (cnt0 < 4 || cnt1 < 4); c++) begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk); #1;
            if (hs[0]) begin
                order.push_back(0); times.push_back(cyc); cnt0++;
                if (cnt0 == 4) req_valid[0] = 1'b0;
                else begin req_op1_0 = 32'(cnt0 * 3 + 1); end
            end
            if (hs[1]) begin
                order.push_back(1); times.push_back(cyc); cnt1++;
                if (cnt1 == 4) req_valid[1] = 1'b0;
                else begin
                    req_ctrl1 = p1_ctrl[cnt1];
                    req_op1_1 = 32'hF0F0_0000 + 32'(cnt1);
                    req_op2_1 = 32'(cnt1 + 1);
                end
            end
        end
        chk("t2_cnt0", 64'(cnt0), 64'd4);
        chk("t2_cnt1", 64'(cnt1), 64'd4);
        for (int k = 0; k < order.size(); k++) begin
            chk("t2_order", 64'(order[k]), 64'(k % 2));
            if (k > 0) chk("t2_gap", 64'(times[k] - times[k-1]), 64'd3);
        end
        repeat (4) @(posedge clk);
        #1;

        // 6: reset during evaluate
        issue(0, 4'h0, 32'd1, 32'd2);
        #2;
        rst_n = 1'b0;
        req_valid = 2'b10;
        #1;
        chk("t6_alu_op1", 64'(alu_op1), 64'd0);
        chk("t6_alu_ctrl", 64'(alu_ctrl), 64'd0);
        chk("t6_req_ready", 64'(req_ready), 64'd0);
        chk("t6_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("t6_rsp_result", 64'(rsp_result), 64'd0);
        @(posedge clk); #2;
        req_valid = 2'b00;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6_no_rsp", 64'(rsp_valid), 64'd0);
        end
        @(posedge clk); #1;
        req_ctrl0 = 4'h4; req_op1_0 = 32'hA5; req_op2_0 = 32'h0F;
        req_ctrl1 = 4'hF; req_op1_1 = 32'd3; req_op2_1 = 32'd4;
        req_valid = 2'b11;
        @(negedge clk);
        chk("t6_first_grant", 64'(req_ready), 64'b01);
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (5) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
